// File: rtl/u409_ata_timing_pkg.sv
// Shared state encoding, request attributes and default PIO timing
// constants for the ATA PIO strobe timing generator.
package u409_pkg;

    localparam int unsigned CNT_W = 6;

    localparam int unsigned D_M0_SETUP    = 3;
    localparam int unsigned D_M0_STROBE   = 7;
    localparam int unsigned D_M0_RECOVER  = 14;
    localparam int unsigned D_M4_SETUP    = 1;
    localparam int unsigned D_M4_STROBE   = 3;
    localparam int unsigned D_M4_RECOVER  = 1;
    localparam int unsigned D_RDY_TIMEOUT = 50;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_EXTEND,
        ST_RECOVER
    } state_t;

    typedef struct packed {
        logic rnw;
        logic sec;
        logic mode4;
    } req_t;

    // A phase of n clocks counts n-1 down to 0.
    function automatic logic [CNT_W-1:0] ld_val(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/u409_ata_timing_if.sv
// CPU-side start strobe, channel mode selects, IORDY and ATA strobe
// outputs of the PIO timing generator.
interface u409_ata_timing_if;
    logic TSn;
    logic RnW;
    logic ATA_SPACE;
    logic SEC;
    logic PPIO;
    logic SPIO;
    logic IORDY;
    logic DIORn;
    logic DIOWn;
    logic ATA_TACK;
    logic ATA_BUSY;
    logic RDY_TO;

    modport master (
        output TSn, RnW, ATA_SPACE, SEC, PPIO, SPIO, IORDY,
        input  DIORn, DIOWn, ATA_TACK, ATA_BUSY, RDY_TO
    );

    modport slave (
        input  TSn, RnW, ATA_SPACE, SEC, PPIO, SPIO, IORDY,
        output DIORn, DIOWn, ATA_TACK, ATA_BUSY, RDY_TO
    );
endinterface

// File: rtl/u409_ata_timing_cnt.sv
// Loadable 6-bit down-counter; holds at zero and flags the terminal count.
module u409_ata_cnt
    import u409_pkg::*;
(
    input  logic             CLK40,
    input  logic             RESET,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/u409_ata_timing.sv
// ATA PIO mode 0 / mode 4 strobe sequencer with IORDY extension,
// timeout and a single pending request slot.
module u409_ata_timing
    import u409_pkg::*;
#(
    parameter int unsigned M0_SETUP    = D_M0_SETUP,
    parameter int unsigned M0_STROBE   = D_M0_STROBE,
    parameter int unsigned M0_RECOVER  = D_M0_RECOVER,
    parameter int unsigned M4_SETUP    = D_M4_SETUP,
    parameter int unsigned M4_STROBE   = D_M4_STROBE,
    parameter int unsigned M4_RECOVER  = D_M4_RECOVER,
    parameter int unsigned RDY_TIMEOUT = D_RDY_TIMEOUT
) (
    input  logic              CLK40,
    input  logic              RESET,
    u409_ata_timing_if.slave  ata
);

    state_t           r_state;
    state_t           w_nxt;
    req_t             r_cur;
    req_t             r_pend;
    req_t             w_in;
    req_t             w_nxt_req;
    logic             r_pend_v;
    logic             w_start;
    logic             w_tc;
    logic             w_load;
    logic [CNT_W-1:0] w_ld_val;
    logic             w_fin;
    logic             w_strobe;
    logic             w_diorn;
    logic             w_diown;
    logic             w_tack;
    logic             w_busy;
    logic             w_rdy_to;

    assign w_start = !ata.TSn && ata.ATA_SPACE;
    assign w_in    = '{rnw:   ata.RnW,
                       sec:   ata.SEC,
                       mode4: ata.SEC ? ata.SPIO : ata.PPIO};
    assign w_fin   = (r_state == ST_RECOVER) && w_tc;

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt     = r_state;
        w_nxt_req = r_cur;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_nxt     = ST_SETUP;
                    w_nxt_req = w_in;
                end
            end
            ST_SETUP: begin
                if (w_tc) w_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                if (w_tc) w_nxt = ata.IORDY ? ST_RECOVER : ST_EXTEND;
            end
            ST_EXTEND: begin
                if (ata.IORDY || w_tc) w_nxt = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (w_tc) begin
                    if (r_pend_v) begin
                        w_nxt     = ST_SETUP;
                        w_nxt_req = r_pend;
                    end else if (w_start) begin
                        w_nxt     = ST_SETUP;
                        w_nxt_req = w_in;
                    end else begin
                        w_nxt     = ST_IDLE;
                    end
                end
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_strobe = (r_state == ST_STROBE) || (r_state == ST_EXTEND);
        w_diorn  = !(w_strobe && r_cur.rnw);
        w_diown  = !(w_strobe && !r_cur.rnw);
        w_busy   = (r_state != ST_IDLE);
        w_tack   = 1'b0;
        w_rdy_to = 1'b0;
        if (!RESET) begin
            if (r_state == ST_STROBE) begin
                w_tack = w_tc && ata.IORDY;
            end else if (r_state == ST_EXTEND) begin
                w_tack   = ata.IORDY || w_tc;
                w_rdy_to = w_tc && !ata.IORDY;
            end
        end
    end

    assign ata.DIORn    = w_diorn;
    assign ata.DIOWn    = w_diown;
    assign ata.ATA_TACK = w_tack;
    assign ata.ATA_BUSY = w_busy;
    assign ata.RDY_TO   = w_rdy_to;

    // Attributes are frozen at latch time so mode pins can move mid-cycle.
    always_ff @(posedge CLK40) begin
        if (RESET) begin
            r_cur    <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
        end else begin
            r_cur <= w_nxt_req;
            if (w_fin && r_pend_v) begin
                r_pend_v <= 1'b0;
            end else if (w_start && !r_pend_v && !w_fin
                         && r_state != ST_IDLE) begin
                r_pend_v <= 1'b1;
                r_pend   <= w_in;
            end
        end
    end

    assign w_load = (w_nxt != r_state);

    always_comb begin
        w_ld_val = '0;
        unique case (w_nxt)
            ST_SETUP:
                w_ld_val = ld_val(w_nxt_req.mode4 ? M4_SETUP : M0_SETUP);
            ST_STROBE:
                w_ld_val = ld_val(w_nxt_req.mode4 ? M4_STROBE : M0_STROBE);
            ST_EXTEND:
                w_ld_val = ld_val(RDY_TIMEOUT);
            ST_RECOVER:
                w_ld_val = ld_val(w_nxt_req.mode4 ? M4_RECOVER : M0_RECOVER);
            default:
                w_ld_val = '0;
        endcase
    end

    u409_ata_cnt u_cnt (
        .CLK40  (CLK40),
        .RESET  (RESET),
        .i_load (w_load),
        .i_val  (w_ld_val),
        .o_tc   (w_tc)
    );

endmodule
